failval_arb: RTL

FAILVAL_ARB -- requirements
Module: failval_arb

---
 rtl/failval_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/failval_arb.sv
// Two-requester arbiter sharing one in-order fail-value read port; a tag FIFO routes returns.
// Define FAILVAL_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module failval_arb #(
  parameter int W_DATA = 13,
  parameter int W_ADDR = 12,
  parameter int DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req0_valid,
  output logic                            req0_ready,
  input  logic [W_ADDR-1:0]               req0_addr,
  input  logic                            req1_valid,
  output logic                            req1_ready,
  input  logic [W_ADDR-1:0]               req1_addr,
  output logic                            rsp0_valid,
  input  logic                            rsp0_ready,
  output logic signed [W_DATA-1:0]        rsp0_data,
  output logic                            rsp1_valid,
  input  logic                            rsp1_ready,
  output logic signed [W_DATA-1:0]        rsp1_data,
  output logic                            mem_addr_valid,
  input  logic                            mem_addr_ready,
  output logic [W_ADDR-1:0]               mem_addr,
  input  logic                            mem_data_valid,
  output logic                            mem_data_ready,
  input  logic signed [W_DATA-1:0]        mem_data,
  output logic [$clog2(DEPTH+1)-1:0]      outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] tag_mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             lock_q;
  logic             lock_sel_q;
  logic             sel;
  logic             sel_valid;
  logic             full;
  logic             empty;
  logic             grant_ok;
  logic             push;
  logic             pop;
  logic             head;
  logic             both_pick;

`ifdef FAILVAL_ARB_RR_EN
  logic last_grant_q;

  assign both_pick = ~last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (push) begin
      last_grant_q <= sel;
    end
  end
`else
  assign both_pick = 1'b0;
`endif

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  // A stalled address keeps its requester selected until the read port takes it.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (req0_valid && req1_valid) begin
      sel = both_pick;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign sel_valid      = sel ? req1_valid : req0_valid;
  assign mem_addr_valid = !rst && sel_valid && !full;
  assign mem_addr       = sel ? req1_addr : req0_addr;
  assign grant_ok       = !rst && mem_addr_ready && !full;
  assign req0_ready     = grant_ok && !sel;
  assign req1_ready     = grant_ok && sel;
  assign push           = mem_addr_valid && mem_addr_ready;

  assign rsp0_valid     = !rst && mem_data_valid && !empty && !head;
  assign rsp1_valid     = !rst && mem_data_valid && !empty && head;
  assign rsp0_data      = mem_data;
  assign rsp1_data      = mem_data;
  assign mem_data_ready = !rst && !empty && (head ? rsp1_ready : rsp0_ready);
  assign pop            = mem_data_valid && mem_data_ready;

  assign outstanding    = count;

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= sel;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      lock_q     <= mem_addr_valid && !mem_addr_ready;
      lock_sel_q <= sel;
    end
  end

endmodule
